// File: rtl/fetch_ir_unit.sv
// PC and instruction register for the multicycle 16-bit core.
// Define FETCH_PERF_EN to add the fetch_count / wait_total counters.
module fetch_ir_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          TIMEOUT  = 15,
   parameter logic [15:0] ERR_INST = 16'h0007
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        IRWrite,
   input  logic        PCWrite,
   input  logic        PCWriteCond,
   input  logic        PCSrc,
   input  logic [15:0] alu_result,
   input  logic [15:0] alu_out,
   input  logic        alu_zero,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   output logic [15:0] inst,
   output logic [15:0] pc,
   output logic        stall,
   output logic        fetch_err,
   output logic        misalign
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] fetch_count,
   output logic [15:0] wait_total
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [7:0] LAST   = 8'(TIMEOUT - 1);

   logic [1:0]  state;
   logic [7:0]  wcnt;
   logic        pc_en;
   logic        finish;
   logic [15:0] nxt;

   assign stall    = (state == S_IDLE && IRWrite) || state == S_WAIT;
   assign mem_addr = pc;
   assign finish   = state == S_WAIT && (mem_ready || wcnt == LAST);
   assign pc_en    = !stall && (PCWrite || (PCWriteCond && !alu_zero));
   assign nxt      = PCSrc ? alu_out : alu_result;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         wcnt      <= '0;
         mem_req   <= 1'b0;
         inst      <= '0;
         fetch_err <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (IRWrite) begin
                  state   <= S_WAIT;
                  mem_req <= 1'b1;
                  wcnt    <= '0;
               end
            end
            S_WAIT: begin
               // ready on the last allowed cycle still wins over timeout
               if (mem_ready) begin
                  inst    <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= S_DONE;
               end else if (wcnt == LAST) begin
                  inst      <= ERR_INST;
                  fetch_err <= 1'b1;
                  mem_req   <= 1'b0;
                  state     <= S_DONE;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pc       <= RESET_PC;
         misalign <= 1'b0;
      end else if (pc_en) begin
         pc <= {nxt[15:1], 1'b0};
         if (nxt[0]) misalign <= 1'b1;
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         fetch_count <= '0;
         wait_total  <= '0;
      end else begin
         if (finish && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
         if (state == S_WAIT && wait_total != 16'hFFFF)
            wait_total <= wait_total + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ir_unit.sv
// Scoreboard bench for fetch_ir_unit: random fetches and PC updates
// checked against a transaction-level model.
module tb_fetch_ir_unit;
   localparam int          TO  = 15;
   localparam logic [15:0] ERR = 16'h0007;
   localparam logic [15:0] RPC = 16'h0000;

   logic        CLK, Reset, IRWrite, PCWrite, PCWriteCond, PCSrc;
   logic [15:0] alu_result, alu_out, mem_rdata;
   logic        alu_zero, mem_ready;
   logic        mem_req, stall, fetch_err, misalign;
   logic [15:0] mem_addr, inst, pc;
`ifdef FETCH_PERF_EN
   logic [15:0] fetch_count, wait_total;
`endif

   fetch_ir_unit #(.RESET_PC(RPC), .TIMEOUT(TO), .ERR_INST(ERR)) dut (
      .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .alu_result(alu_result),
      .alu_out(alu_out), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
      .inst(inst), .pc(pc), .stall(stall), .fetch_err(fetch_err),
      .misalign(misalign)
`ifdef FETCH_PERF_EN
      , .fetch_count(fetch_count), .wait_total(wait_total)
`endif
   );

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [15:0] inst;
      logic        err;
      int          stall;
      logic [15:0] addr;
   } fexp_t;

   typedef struct {
      logic [15:0] pc;
      logic        mis;
      logic [15:0] inst;
      logic        err;
   } cexp_t;

   fexp_t fq[$];
   cexp_t cq[$];

   int n_chk = 0;
   int n_fail = 0;

   logic [15:0] m_pc, m_inst;
   logic        m_mis, m_err, m_stall;
   int          m_fc, m_wt;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: per-cycle state and per-fetch completion records
   int          scnt = 0;
   bit          bad = 0;
   logic [15:0] addr0;
   always @(negedge CLK) begin
      if (Reset) begin
         scnt = 0;
         bad  = 0;
      end else begin
         if (cq.size() > 0) begin
            cexp_t c;
            c = cq.pop_front();
            check("pc", pc, c.pc);
            check("misalign", misalign, c.mis);
            check("inst_hold", inst, c.inst);
            check("fetch_err", fetch_err, c.err);
         end
         if (stall) begin
            if (scnt == 0) addr0 = mem_addr;
            else if (!mem_req || mem_addr !== addr0) bad = 1;
            scnt++;
         end else if (scnt > 0) begin
            if (fq.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               fexp_t e;
               e = fq.pop_front();
               check("done_inst", inst, e.inst);
               check("done_err", fetch_err, e.err);
               check("stall_len", scnt, e.stall);
               check("fetch_addr", addr0, e.addr);
               check("req_stable", bad, 0);
               check("req_dropped", mem_req, 0);
            end
            scnt = 0;
            bad  = 0;
         end
      end
   end

   // One clock cycle: record what should be visible now, then advance model
   task automatic step();
      logic [15:0] n;
      cq.push_back('{m_pc, m_mis, m_inst, m_err});
      if (!m_stall && (PCWrite || (PCWriteCond && !alu_zero))) begin
         n = PCSrc ? alu_out : alu_result;
         m_pc = n & 16'hFFFE;
         if (n[0]) m_mis = 1;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic fetch(int waits, logic [15:0] data, logic [15:0] nxt);
      fexp_t e;
      bit to;
      int nw;
      to = waits >= TO;
      nw = to ? TO : waits + 1;
      e.inst  = to ? ERR : data;
      e.err   = m_err | to;
      e.stall = nw + 1;
      e.addr  = m_pc;
      fq.push_back(e);
      IRWrite = 1; PCWrite = 1; PCWriteCond = 1'($urandom);
      PCSrc = 0; alu_result = 16'($urandom); alu_zero = 0;
      mem_ready = 0; m_stall = 1;
      step();
      for (int i = 0; i < nw; i++) begin
         IRWrite    = 1'($urandom);
         mem_ready  = (i == waits);
         mem_rdata  = (i == waits) ? data : 16'($urandom);
         alu_result = 16'($urandom);
         step();
      end
      m_inst = e.inst; m_err = e.err; m_fc++; m_wt += nw;
      m_stall = 0; IRWrite = 1'($urandom); mem_ready = 1'($urandom);
      mem_rdata = 16'($urandom); PCWriteCond = 0; alu_result = nxt;
      step();
      IRWrite = 0; PCWrite = 0; mem_ready = 0;
   endtask

   task automatic pc_op(bit w, bit c, bit s, logic [15:0] r,
                        logic [15:0] o, bit z);
      IRWrite = 0; PCWrite = w; PCWriteCond = c; PCSrc = s;
      alu_result = r; alu_out = o; alu_zero = z;
      mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
      m_stall = 0;
      step();
      PCWrite = 0; PCWriteCond = 0; mem_ready = 0;
   endtask

   task automatic model_reset();
      m_pc = RPC; m_inst = 0; m_mis = 0; m_err = 0;
      m_stall = 0; m_fc = 0; m_wt = 0;
   endtask

   initial begin
      Reset = 1; IRWrite = 0; PCWrite = 0; PCWriteCond = 0; PCSrc = 0;
      alu_result = 0; alu_out = 0; alu_zero = 0;
      mem_ready = 0; mem_rdata = 0;
      model_reset();
      #3;
      check("rst_pc", pc, RPC);
      check("rst_inst", inst, 0);
      check("rst_req", mem_req, 0);
      check("rst_err", fetch_err, 0);
      check("rst_mis", misalign, 0);
      check("rst_stall", stall, 0);
      @(posedge CLK); #1;
      Reset = 0;

      fetch(0, 16'h1238, 16'h0002);
      pc_op(0, 0, 0, 16'h0, 16'h0, 0);
      fetch(4, 16'hBEEF, 16'h0004);
      fetch(20, 16'h5555, 16'h0006);
      fetch(3, 16'h2222, 16'h0008);

      // abort a fetch with reset in the middle of WAIT
      IRWrite = 1; PCWrite = 1; mem_ready = 0; m_stall = 1;
      step();
      IRWrite = 0;
      step();
      step();
      #2 Reset = 1;
      #1;
      check("mid_rst_req", mem_req, 0);
      check("mid_rst_pc", pc, RPC);
      check("mid_rst_inst", inst, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_err", fetch_err, 0);
      cq.delete();
      model_reset();
      PCWrite = 0; mem_ready = 1; mem_rdata = 16'hDEAD;
      @(posedge CLK); #1;
      Reset = 0;
      step();
      mem_ready = 0;
      step();

      fetch(0, 16'h1111, 16'h0002);
      fetch(2, 16'h2222, 16'h0004);
      fetch(4, 16'h3333, 16'h0006);
`ifdef FETCH_PERF_EN
      check("perf_count", fetch_count, 3);
      check("perf_wait", wait_total, 9);
`endif
      fetch(14, 16'h4444, 16'h0008);

      pc_op(0, 1, 1, 16'h1234, 16'h0040, 0);
      pc_op(0, 1, 1, 16'h1234, 16'h0080, 1);
      pc_op(1, 1, 1, 16'h1234, 16'h0100, 1);
      pc_op(1, 0, 0, 16'h0013, 16'h0000, 0);
      pc_op(1, 0, 0, 16'hFFFE, 16'h0000, 0);
      pc_op(1, 0, 0, 16'h0000, 16'h0000, 0);

      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 1) == 0)
            fetch($urandom_range(0, 18), 16'($urandom),
                  16'($urandom) & 16'hFFFE);
         else
            pc_op(1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom));
      end

      @(negedge CLK); #1;
      check("fq_drained", fq.size(), 0);
`ifdef FETCH_PERF_EN
      check("perf_count_end", fetch_count, m_fc);
      check("perf_wait_end", wait_total, m_wt);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_ir_unit.md
Name: fetch_ir_unit

Overview:
Owns the program counter and instruction register of the multicycle 16-bit core, directly upstream of the controller. It drives `inst` into the controller and performs instruction fetches over a variable-latency memory handshake. It asserts `stall` so the controller holds its Fetch state until the instruction word is captured. It applies the controller's PC-update commands (PCWrite, PCWriteCond, PCSrc) using ALU results from the datapath.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT, 15, maximum WAIT cycles before a fetch is abandoned; range 1..255.
- ERR_INST, 16'h0007, word loaded into IR on timeout. Opcode 7 is undefined, so the controller returns to Fetch.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IRWrite  in  1  controller request to fetch into IR.
- PCWrite  in  1  unconditional PC load.
- PCWriteCond  in  1  conditional PC load (bne).
- PCSrc  in  1  0 = alu_result, 1 = alu_out.
- alu_result  in  16  combinational ALU output.
- alu_out  in  16  registered ALUOut.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has read data valid this cycle.
- mem_rdata  in  16  memory read data.
- mem_req  out  1  fetch read request, registered.
- mem_addr  out  16  fetch address (= pc).
- inst  out  16  IR contents to the controller and datapath.
- pc  out  16  current PC.
- stall  out  1  controller must hold its current state.
- fetch_err  out  1  sticky timeout flag.
- misalign  out  1  sticky: a PC load had bit0 = 1.

Behaviour:
- Reset (async, any state, including mid-fetch):
  - state = IDLE, pc = RESET_PC, inst = 0.
  - mem_req = 0, fetch_err = 0, misalign = 0, wait counter = 0.
  - A late mem_ready arriving after reset is ignored.
- States: IDLE, WAIT, DONE.
- IDLE:
  - IRWrite = 1 → WAIT next edge, mem_req <= 1, wait counter <= 0.
  - mem_ready while in IDLE is ignored.
- WAIT:
  - mem_req held 1; mem_addr = pc held stable.
  - mem_ready = 1 → inst <= mem_rdata, mem_req <= 0, → DONE.
  - Otherwise the wait counter increments. When counter == TIMEOUT-1 with no ready:
    - inst <= ERR_INST, fetch_err <= 1, mem_req <= 0, → DONE.
  - mem_ready on the timeout cycle wins: data is captured and fetch_err is not set.
- DONE: one cycle, → IDLE unconditionally. IRWrite is ignored here, because the controller is still in Fetch for this edge.
- stall = (state==IDLE && IRWrite) || state==WAIT. This is combinational; DONE and idle-without-request give 0.
- Minimum fetch latency:
  - Request edge, ready in first WAIT cycle, capture edge.
  - stall is high for 2 cycles, inst is valid in DONE.
- PC update:
  - pc_en = !stall && (PCWrite || (PCWriteCond && !alu_zero)).
  - The Fetch-state PCWrite therefore takes effect only in the DONE cycle.
  - next = PCSrc ? alu_out : alu_result.
  - pc <= {next[15:1], 1'b0}; if next[0] = 1, misalign <= 1 (sticky).
- PCWrite and PCWriteCond both high → PCWrite dominates (unconditional load).
- pc is unchanged while stall = 1, regardless of PCWrite.
- 16-bit PC wraps naturally (16'hFFFE + 2 = 16'h0000); no flag.
- inst changes only on capture or timeout; it holds between fetches.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Extra output ports fetch_count[15:0] and wait_total[15:0], both reset to 0 and saturating at 16'hFFFF.
  - fetch_count increments on each transition into DONE.
  - wait_total increments on each cycle spent in WAIT.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then IRWrite held, mem_ready on the 1st WAIT cycle with rdata=16'h1238 → mem_addr=0, stall high 2 cycles, inst=16'h1238 in DONE. PCWrite with alu_result=2, PCSrc=0 → pc=2 after DONE.
- mem_ready delayed 5 cycles → mem_req and mem_addr stable throughout, stall high 6 cycles, pc unchanged until DONE.
- No mem_ready, TIMEOUT=15 → after 15 WAIT cycles inst=16'h0007, fetch_err=1 (sticky through the next good fetch). Repeat with ready on cycle 15 → data captured, fetch_err stays 0.
- PCWriteCond=1, PCSrc=1, alu_out=16'h0040:
  - alu_zero=0 → pc=16'h0040.
  - alu_zero=1 → pc unchanged.
  - Also PCWrite=1 with alu_result=16'h0013 → pc=16'h0012, misalign=1.
- Reset asserted mid-WAIT, then mem_ready pulse → mem_req=0 immediately, pc=RESET_PC, inst=0, state IDLE, the late ready ignored.
- FETCH_PERF_EN defined, 3 fetches with waits 0, 2, 4 → fetch_count=3, wait_total=9 (WAIT cycles = waits + 1 each).
